// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_arbiter: owner tag of the single in-flight memory read.
// Latency: none (constants only). Backpressure: not applicable.
package mem_arb_pkg;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_DATA  = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a 1R1W memory; MEM_ARB_STARVE_EN adds a fetch starvation guard.
// Latency: grants are combinational and read data returns one cycle later. Responses cannot be back-pressured.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_req,
   input  logic [29:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [29:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic        m_rready,
   output logic        m_wready,
   output logic [29:0] m_raddr,
   output logic [29:0] m_waddr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata
);

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be at least 1");
   end

   logic       fetch_wins;
   logic       d_rd_gnt;
   logic       d_wr_gnt;
   logic [1:0] resp_own;

`ifdef MEM_ARB_STARVE_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0] starve_cnt;

   assign fetch_wins = (starve_cnt == SC_W'(STARVE_MAX));

   // Saturates at STARVE_MAX; the forced fetch grant that follows clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!i_req || i_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign fetch_wins = 1'b0;
`endif

   always_comb begin
      i_gnt    = 1'b0;
      d_rd_gnt = 1'b0;
      d_wr_gnt = 1'b0;
      if (!rst) begin
         d_wr_gnt = d_req && d_we;
         if (d_req && !d_we) begin
            // Only one read port: data takes it unless fetch has been starved out.
            d_rd_gnt = !(i_req && fetch_wins);
            i_gnt    = i_req && fetch_wins;
         end else begin
            i_gnt = i_req;
         end
      end
   end

   assign d_gnt = d_rd_gnt || d_wr_gnt;

   always_comb begin
      m_rready = i_gnt || d_rd_gnt;
      m_raddr  = '0;
      if (i_gnt) begin
         m_raddr = i_addr;
      end else if (d_rd_gnt) begin
         m_raddr = d_addr;
      end

      m_wready = d_wr_gnt;
      m_waddr  = d_wr_gnt ? d_addr  : '0;
      m_wdata  = d_wr_gnt ? d_wdata : '0;
      m_wstrb  = d_wr_gnt ? d_wstrb : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_own <= OWN_NONE;
      end else if (i_gnt) begin
         resp_own <= OWN_FETCH;
      end else if (d_rd_gnt) begin
         resp_own <= OWN_DATA;
      end else begin
         resp_own <= OWN_NONE;
      end
   end

   // Memory read data is shared; rvalid alone tells each requester it is theirs.
   assign i_rvalid = (resp_own == OWN_FETCH);
   assign d_rvalid = (resp_own == OWN_DATA);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-clock memory model between the instruction-fetch port and the load/store data port of the three-stage core. It issues at most one read and one write to the memory per cycle. A fetch read and a data write may proceed in the same cycle. When a fetch read and a data read collide, the arbiter picks a winner and tracks which requester owns the in-flight read, so that the registered read data is steered back one cycle later.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive lost fetch cycles after which fetch wins the next read conflict (only with starvation guard, see Configuration).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch read request; held with i_addr until granted
- i_addr  in  30  fetch word address [31:2]
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  30  data word address [31:2]
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes for writes
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered)
- d_rdata  out  32  load data
- m_rready, m_wready  out  1 each  memory read/write enables
- m_raddr, m_waddr  out  30 each  memory word addresses
- m_wdata  out  32; m_wstrb  out  4  memory write data/strobes
- m_rdata  in  32  memory read data, valid the cycle after m_rready

## Operation
- Grant rules, evaluated combinationally each cycle:
  - i_req alone: grant fetch read.
  - d_req & d_we alone: grant write.
  - d_req & !d_we alone: grant data read.
  - i_req & d_req & d_we: grant both. m_raddr = i_addr, m_waddr = d_addr. Same-address read returns the merged new data (memory forwarding).
  - i_req & d_req & !d_we: read conflict. Data wins unless the starvation guard fires.
- Read owner: a 2-bit register resp_own (NONE/FETCH/DATA), loaded each cycle with the owner of the read granted that cycle, or NONE if no read was granted.
- Responses:
  - i_rvalid = (resp_own == FETCH), d_rvalid = (resp_own == DATA).
  - i_rdata = d_rdata = m_rdata.
  - Requesters must accept responses unconditionally; there is no response back-pressure.
- Memory outputs when no operation is granted: m_rready = m_wready = 0; addresses/data are don't-care (drive 0).
- Writes never produce a response.

## Timing
- Request accepted in cycle T (gnt=1). Read data and rvalid arrive in T+1. Back-to-back reads are possible at 1 per cycle.
- A write granted in T is visible to a read granted in T+1.
- Reset values: resp_own=NONE, starve_cnt=0, i_rvalid=d_rvalid=0.
- While rst=1, i_gnt=d_gnt=m_rready=m_wready=0.
- Reset mid-operation: a read granted before reset asserts produces no rvalid after reset releases.
- A fetch that loses arbitration holds its request. Its grant comes in the first cycle it wins; it is never dropped.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - Saturating counter starve_cnt, width $clog2(STARVE_MAX+1).
  - Increments on each cycle with i_req & !i_gnt; clears when i_gnt=1 or i_req=0.
  - When starve_cnt == STARVE_MAX, fetch wins the next read conflict, then the counter clears.
- Undefined: strict data priority. Fetch can starve indefinitely under continuous data reads. No counter logic.

## Structure
- Shared package mem_arb_pkg holds the resp_own encoding constants (OWN_NONE=2'd0, OWN_FETCH=2'd1, OWN_DATA=2'd2).
- Single module; no sub-modules. The grant logic is small enough to stay inline.

## Test plan
- Fetch-only read: i_req, i_addr=0x10. Expect i_gnt in T; i_rvalid and i_rdata=mem[0x10] in T+1; d_rvalid=0.
- Concurrent fetch read + data write to the same address 0x20, wstrb=4'b0011, wdata=0xAABBCCDD, mem[0x20]=0x11223344. Expect both granted in T; i_rdata=0x1122CCDD in T+1.
- Read conflict without the macro: i_req and d_req (read) held for 10 cycles. Expect d_gnt every cycle, i_gnt never, d_rvalid for cycles T+1..T+10.
- Read conflict with MEM_ARB_STARVE_EN, STARVE_MAX=4, both held. Expect d_gnt for 4 cycles, then i_gnt in the 5th, and the repeating pattern 4:1.
- Write then read: d write 0xDEADBEEF to 0x40, wstrb=4'hF, in T; d read 0x40 in T+1. Expect d_rdata=0xDEADBEEF in T+2.
- Reset mid-read: grant fetch read in T, assert rst before T+1 edge. Expect i_rvalid=0 throughout reset and after release.
